// File: rtl/seq_pattern_tx.sv
// -----------------------------------------------------------------------------
// seq_pattern_tx
//   Serial pattern transmitter. It captures a PAT_W-bit pattern and shifts it
//   out MSB-first on x_out, one bit per clock. The pattern is repeated repeat_n
//   times, with an optional idle gap of `gap` cycles between repetitions.
//   x_out feeds the x input of the Moore sequence detector directly.
//
//   Optional feature macro: PARITY_EN
//     When defined, an even-parity bit (XOR of the pattern) is appended after
//     bit 0 of every repetition.
//
// Ports
//   clk        rising-edge clock, one serial bit per cycle
//   rst        synchronous active-low reset
//   start      transfer request, honoured only in IDLE
//   pattern    pattern to send (captured with start)
//   repeat_n   repetition count (captured with start); 0 = no transfer
//   gap        idle cycles between repetitions (captured with start)
//   abort      synchronous abort of a transfer in progress
//   x_out      registered serial data
//   valid      x_out carries a pattern (or parity) bit
//   frame_sync high on the MSB of each repetition
//   busy       high in SEND, GAP and DONE
//   done       one-cycle pulse after the last repetition
// -----------------------------------------------------------------------------
module seq_pattern_tx #(
   parameter int PAT_W = 4,
   parameter int CNT_W = 8,
   parameter int GAP_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [PAT_W-1:0] pattern,
   input  logic [CNT_W-1:0] repeat_n,
   input  logic [GAP_W-1:0] gap,
   input  logic             abort,
   output logic             x_out,
   output logic             valid,
   output logic             frame_sync,
   output logic             busy,
   output logic             done
);

   localparam int IDX_W = $clog2(PAT_W);
   localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(PAT_W - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_SEND = 2'd1;
   localparam logic [1:0] S_GAP  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]       state, state_n;
   logic [PAT_W-1:0] pat, pat_n;
   logic [CNT_W-1:0] rem, rem_n;
   logic [GAP_W-1:0] gap_len, gap_len_n;
   logic [GAP_W-1:0] gcnt, gcnt_n;
   logic [IDX_W-1:0] idx, idx_n;
   logic             x_n, valid_n, fs_n, busy_n, done_n;
   logic             last_bit;
`ifdef PARITY_EN
   logic             par_ph, par_ph_n;
`endif

   // Next-state and next-output logic. Outputs are computed for the cycle
   // that follows the edge, so every output comes straight from a flop.
   always_comb begin
      state_n   = state;
      pat_n     = pat;
      rem_n     = rem;
      gap_len_n = gap_len;
      gcnt_n    = gcnt;
      idx_n     = idx;
      x_n       = 1'b0;
      valid_n   = 1'b0;
      fs_n      = 1'b0;
      busy_n    = 1'b0;
      done_n    = 1'b0;
`ifdef PARITY_EN
      par_ph_n  = 1'b0;
      last_bit  = par_ph;
`else
      last_bit  = (idx == '0);
`endif

      case (state)
         S_IDLE: begin
            if (start && (repeat_n != '0)) begin
               state_n   = S_SEND;
               pat_n     = pattern;
               rem_n     = repeat_n;
               gap_len_n = gap;
               idx_n     = IDX_MSB;
               x_n       = pattern[PAT_W-1];
               valid_n   = 1'b1;
               fs_n      = 1'b1;
               busy_n    = 1'b1;
            end
         end

         S_SEND: begin
            busy_n = 1'b1;
            if (last_bit) begin
               // End of one repetition: count it and choose what follows.
               rem_n = rem - CNT_W'(1);
               idx_n = IDX_MSB;
               if (rem == CNT_W'(1)) begin
                  state_n = S_DONE;
                  done_n  = 1'b1;
               end else if (gap_len != '0) begin
                  state_n = S_GAP;
                  gcnt_n  = gap_len;
               end else begin
                  x_n     = pat[PAT_W-1];
                  valid_n = 1'b1;
                  fs_n    = 1'b1;
               end
            end
`ifdef PARITY_EN
            else if (idx == '0) begin
               par_ph_n = 1'b1;
               x_n      = ^pat;
               valid_n  = 1'b1;
            end
`endif
            else begin
               idx_n   = idx - IDX_W'(1);
               x_n     = pat[idx_n];
               valid_n = 1'b1;
            end
         end

         S_GAP: begin
            busy_n = 1'b1;
            // gcnt holds the idle cycles still to be shown, including this one.
            if (gcnt == GAP_W'(1)) begin
               state_n = S_SEND;
               idx_n   = IDX_MSB;
               x_n     = pat[PAT_W-1];
               valid_n = 1'b1;
               fs_n    = 1'b1;
            end else begin
               gcnt_n = gcnt - GAP_W'(1);
            end
         end

         S_DONE: begin
            state_n = S_IDLE;
         end

         default: begin
            state_n = S_IDLE;
         end
      endcase

      // Abort drops any transfer in progress without a done pulse.
      if (abort && (state != S_IDLE)) begin
         state_n = S_IDLE;
         x_n     = 1'b0;
         valid_n = 1'b0;
         fs_n    = 1'b0;
         busy_n  = 1'b0;
         done_n  = 1'b0;
`ifdef PARITY_EN
         par_ph_n = 1'b0;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= S_IDLE;
         pat        <= '0;
         rem        <= '0;
         gap_len    <= '0;
         gcnt       <= '0;
         idx        <= '0;
         x_out      <= 1'b0;
         valid      <= 1'b0;
         frame_sync <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
`ifdef PARITY_EN
         par_ph     <= 1'b0;
`endif
      end else begin
         state      <= state_n;
         pat        <= pat_n;
         rem        <= rem_n;
         gap_len    <= gap_len_n;
         gcnt       <= gcnt_n;
         idx        <= idx_n;
         x_out      <= x_n;
         valid      <= valid_n;
         frame_sync <= fs_n;
         busy       <= busy_n;
         done       <= done_n;
`ifdef PARITY_EN
         par_ph     <= par_ph_n;
`endif
      end
   end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// -----------------------------------------------------------------------------
// tb_seq_pattern_tx
//   Directed bench for seq_pattern_tx. A table of per-cycle records
//   {inputs, expected {x_out,valid,frame_sync,busy,done}} is filled at the top
//   and replayed; hand-written sequences cover reset, abort and reset during
//   a gap. Honours PARITY_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_seq_pattern_tx;

   logic       clk = 1'b0;
   logic       rst, start, abort;
   logic [3:0] pattern;
   logic [7:0] repeat_n;
   logic [3:0] gap;
   logic       x_out, valid, frame_sync, busy, done;

   int ncmp  = 0;
   int nfail = 0;

`ifdef PARITY_EN
   localparam int B = 5;
`else
   localparam int B = 4;
`endif

   // Expected output words: {x_out, valid, frame_sync, busy, done}
   localparam logic [4:0] O_IDLE = 5'b00000;
   localparam logic [4:0] O_GAP  = 5'b00010;
   localparam logic [4:0] O_DONE = 5'b00011;

   typedef struct {
      logic       st;
      logic [3:0] pat;
      logic [7:0] rn;
      logic [3:0] g;
      logic       ab;
      logic       rs;
      logic [4:0] exp;
   } vec_t;

   vec_t vq[$];

   always #5 clk = ~clk;

   seq_pattern_tx #(.PAT_W(4), .CNT_W(8), .GAP_W(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .pattern    (pattern),
      .repeat_n   (repeat_n),
      .gap        (gap),
      .abort      (abort),
      .x_out      (x_out),
      .valid      (valid),
      .frame_sync (frame_sync),
      .busy       (busy),
      .done       (done)
   );

   function automatic logic [4:0] o_bit(input logic b, input logic first);
      return {b, 1'b1, first, 1'b1, 1'b0};
   endfunction

   task automatic push(input logic st, input logic [3:0] pat, input int rn,
                       input int g, input logic ab, input logic rs,
                       input logic [4:0] e);
      vec_t v;
      v.st = st; v.pat = pat; v.rn = 8'(rn); v.g = 4'(g);
      v.ab = ab; v.rs = rs; v.exp = e;
      vq.push_back(v);
   endtask

   // Whole expected train for one clean transfer, plus one trailing idle row.
   task automatic add_xfer(input logic [3:0] pat, input int rn, input int g);
      for (int r = 0; r < rn; r++) begin
         for (int i = 3; i >= 0; i--)
            push((r == 0 && i == 3), pat, rn, g, 1'b0, 1'b1, o_bit(pat[i], i == 3));
`ifdef PARITY_EN
         push(1'b0, pat, rn, g, 1'b0, 1'b1, o_bit(^pat, 1'b0));
`endif
         if (r < rn - 1)
            for (int k = 0; k < g; k++)
               push(1'b0, pat, rn, g, 1'b0, 1'b1, O_GAP);
      end
      push(1'b0, pat, rn, g, 1'b0, 1'b1, O_DONE);
      push(1'b0, pat, rn, g, 1'b0, 1'b1, O_IDLE);
   endtask

   task automatic cyc(input logic st, input logic [3:0] pat, input int rn,
                      input int g, input logic ab, input logic rs);
      @(negedge clk);
      start = st; pattern = pat; repeat_n = 8'(rn); gap = 4'(g);
      abort = ab; rst = rs;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [4:0] e);
      logic [4:0] got;
      got = {x_out, valid, frame_sync, busy, done};
      ncmp++;
      if (got !== e) begin
         nfail++;
         $display("FAIL %s: got {x,v,fs,busy,done}=%b required %b at %0t",
                  name, got, e, $time);
      end
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; abort = 1'b0;
      pattern = '0; repeat_n = '0; gap = '0;

      // ---------------- table fill ----------------
      add_xfer(4'b1010, 3, 0);   // continuous 101010101010, done on cycle 13
      add_xfer(4'b1101, 2, 2);   // 1101 00 1101, done on cycle 11
      // null request
      push(1'b1, 4'b1111, 0, 0, 1'b0, 1'b1, O_IDLE);
      push(1'b0, 4'b1111, 0, 0, 1'b0, 1'b1, O_IDLE);
`ifndef PARITY_EN
      // second start during SEND is ignored
      push(1'b1, 4'b1100, 1, 0, 1'b0, 1'b1, o_bit(1'b1, 1'b1));
      push(1'b1, 4'b0011, 5, 0, 1'b0, 1'b1, o_bit(1'b1, 1'b0));
      push(1'b1, 4'b0011, 5, 0, 1'b0, 1'b1, o_bit(1'b0, 1'b0));
      push(1'b0, 4'b0011, 5, 0, 1'b0, 1'b1, o_bit(1'b0, 1'b0));
      push(1'b0, 4'b0011, 5, 0, 1'b0, 1'b1, O_DONE);
      push(1'b0, 4'b0011, 5, 0, 1'b0, 1'b1, O_IDLE);
      push(1'b0, 4'b0011, 5, 0, 1'b0, 1'b1, O_IDLE);
      // start and abort together in IDLE: start wins
      push(1'b1, 4'b0110, 1, 0, 1'b1, 1'b1, o_bit(1'b0, 1'b1));
      push(1'b0, 4'b0110, 1, 0, 1'b0, 1'b1, o_bit(1'b1, 1'b0));
      push(1'b0, 4'b0110, 1, 0, 1'b0, 1'b1, o_bit(1'b1, 1'b0));
      push(1'b0, 4'b0110, 1, 0, 1'b0, 1'b1, o_bit(1'b0, 1'b0));
      push(1'b0, 4'b0110, 1, 0, 1'b0, 1'b1, O_DONE);
      push(1'b0, 4'b0110, 1, 0, 1'b0, 1'b1, O_IDLE);
`else
      // parity build: 1,0,1,1 then parity 1, done on cycle 6
      push(1'b1, 4'b1011, 1, 0, 1'b0, 1'b1, 5'b11110);
      push(1'b0, 4'b1011, 1, 0, 1'b0, 1'b1, 5'b01010);
      push(1'b0, 4'b1011, 1, 0, 1'b0, 1'b1, 5'b11010);
      push(1'b0, 4'b1011, 1, 0, 1'b0, 1'b1, 5'b11010);
      push(1'b0, 4'b1011, 1, 0, 1'b0, 1'b1, 5'b11010);
      push(1'b0, 4'b1011, 1, 0, 1'b0, 1'b1, O_DONE);
      push(1'b0, 4'b1011, 1, 0, 1'b0, 1'b1, O_IDLE);
`endif

      // ---------------- reset state ----------------
      cyc(1'b1, 4'b1111, 3, 0, 1'b0, 1'b0);
      check("reset_start_ignored", O_IDLE);
      cyc(1'b0, 4'b0000, 0, 0, 1'b0, 1'b0);
      check("reset_hold", O_IDLE);
      cyc(1'b0, 4'b0000, 0, 0, 1'b0, 1'b1);
      check("reset_release", O_IDLE);

      // ---------------- table replay ----------------
      for (int n = 0; n < vq.size(); n++) begin
         cyc(vq[n].st, vq[n].pat, vq[n].rn, vq[n].g, vq[n].ab, vq[n].rs);
         check($sformatf("vec[%0d]", n), vq[n].exp);
      end

      // ---------------- abort on 3rd bit of a 4-repeat transfer ----------------
      cyc(1'b1, 4'b1010, 4, 0, 1'b0, 1'b1);
      check("abort_bit1", o_bit(1'b1, 1'b1));
      cyc(1'b0, 4'b1010, 4, 0, 1'b0, 1'b1);
      check("abort_bit2", o_bit(1'b0, 1'b0));
      cyc(1'b0, 4'b1010, 4, 0, 1'b0, 1'b1);
      check("abort_bit3", o_bit(1'b1, 1'b0));
      cyc(1'b0, 4'b1010, 4, 0, 1'b1, 1'b1);
      check("abort_outputs", O_IDLE);
      for (int k = 0; k < 3; k++) begin
         cyc(1'b0, 4'b1010, 4, 0, 1'b0, 1'b1);
         check("abort_no_done", O_IDLE);
      end
      cyc(1'b1, 4'b0101, 1, 0, 1'b0, 1'b1);
      check("restart_bit1", o_bit(1'b0, 1'b1));
      cyc(1'b0, 4'b0101, 1, 0, 1'b0, 1'b1);
      check("restart_bit2", o_bit(1'b1, 1'b0));
      cyc(1'b0, 4'b0101, 1, 0, 1'b0, 1'b1);
      check("restart_bit3", o_bit(1'b0, 1'b0));
      cyc(1'b0, 4'b0101, 1, 0, 1'b0, 1'b1);
      check("restart_bit4", o_bit(1'b1, 1'b0));
`ifdef PARITY_EN
      cyc(1'b0, 4'b0101, 1, 0, 1'b0, 1'b1);
      check("restart_parity", o_bit(1'b0, 1'b0));
`endif
      cyc(1'b0, 4'b0101, 1, 0, 1'b0, 1'b1);
      check("restart_done", O_DONE);
      cyc(1'b0, 4'b0101, 1, 0, 1'b0, 1'b1);
      check("restart_idle", O_IDLE);

      // ---------------- reset during GAP ----------------
      cyc(1'b1, 4'b1101, 2, 3, 1'b0, 1'b1);
      check("rstgap_bit1", o_bit(1'b1, 1'b1));
      for (int k = 1; k < B; k++)
         cyc(1'b0, 4'b1101, 2, 3, 1'b0, 1'b1);
      cyc(1'b0, 4'b1101, 2, 3, 1'b0, 1'b1);
      check("rstgap_in_gap", O_GAP);
      cyc(1'b0, 4'b1101, 2, 3, 1'b0, 1'b0);
      check("rstgap_outputs", O_IDLE);
      for (int k = 0; k < 3; k++) begin
         cyc(1'b0, 4'b1101, 2, 3, 1'b0, 1'b1);
         check("rstgap_stay_idle", O_IDLE);
      end
      cyc(1'b1, 4'b1001, 1, 0, 1'b0, 1'b1);
      check("rstgap_restart", o_bit(1'b1, 1'b1));
      cyc(1'b0, 4'b1001, 1, 0, 1'b1, 1'b1);
      check("rstgap_final_abort", O_IDLE);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
